// File: rtl/sa_tile_os_param.sv
// Output-stationary NxN systolic MAC tile: operand skew, K-length sequencing, flush,
// and per-row result readout with valid/ready backpressure.
module sa_tile_os_param #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int KW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            signed_mode,
  input  logic [DW:0]     a_offset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] out_row,
  output logic            out_last,
  output logic            busy,
  output logic            done
);
  localparam int OW        = DW + 1;
  localparam int FLUSH_CYC = 2*N - 2;
  localparam int FW        = $clog2(2*N);
  localparam int RW        = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        kcnt_q, kcnt_d;
  logic [KW-1:0]        klen_q, klen_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic                 smode_q, smode_d;
  logic signed [OW-1:0] aoff_q, aoff_d;
  logic                 clr, adv;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    klen_d  = klen_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    smode_d = smode_q;
    aoff_d  = aoff_q;
    clr     = 1'b0;
    done    = 1'b0;
    adv     = ((state_q == S_LOAD) && in_valid) || (state_q == S_FLUSH);
    case (state_q)
      S_IDLE: if (start) begin
        klen_d  = k_len;
        smode_d = signed_mode;
        aoff_d  = a_offset;
        kcnt_d  = '0;
        rcnt_d  = '0;
        clr     = 1'b1;
        state_d = (k_len == '0) ? S_DRAIN : S_LOAD;
      end
      S_LOAD: if (in_valid) begin
        kcnt_d = kcnt_q + KW'(1);
        if (kcnt_q == klen_q - KW'(1)) begin
          fcnt_d  = '0;
          state_d = (FLUSH_CYC == 0) ? S_DRAIN : S_FLUSH;
        end
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q + FW'(1);
        if (fcnt_q == FW'(FLUSH_CYC - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (out_ready) begin
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_q == RW'(N - 1)) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kcnt_q  <= '0;
      klen_q  <= '0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      smode_q <= 1'b0;
      aoff_q  <= '0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      klen_q  <= klen_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      smode_q <= smode_d;
      aoff_q  <= aoff_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign out_last  = (state_q == S_DRAIN) && (rcnt_q == RW'(N - 1));
  assign busy      = (state_q != S_IDLE);

  // Operands are widened to DW+1 signed so one signed multiplier serves both modes.
  logic signed [OW-1:0] a_lane [N];
  logic signed [OW-1:0] b_lane [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_lane[i] = '0;
      b_lane[i] = '0;
      if (state_q != S_FLUSH) begin
        if (smode_q) begin
          a_lane[i] = OW'($signed(a_vec[i*DW +: DW])) + aoff_q;
          b_lane[i] = OW'($signed(b_vec[i*DW +: DW]));
        end else begin
          a_lane[i] = {1'b0, a_vec[i*DW +: DW]};
          b_lane[i] = {1'b0, b_vec[i*DW +: DW]};
        end
      end
    end
  end

  logic signed [OW-1:0] a_pe [N][N];
  logic signed [OW-1:0] b_pe [N][N];
  logic [AW-1:0]        acc  [N][N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_pe[0][0] = a_lane[0];
      assign b_pe[0][0] = b_lane[0];
    end else begin : g_delay
      logic signed [OW-1:0] a_sr_q [i];
      logic signed [OW-1:0] a_sr_d [i];
      logic signed [OW-1:0] b_sr_q [i];
      logic signed [OW-1:0] b_sr_d [i];
      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (clr) begin
          a_sr_d = '{default: '0};
          b_sr_d = '{default: '0};
        end else if (adv) begin
          a_sr_d[0] = a_lane[i];
          b_sr_d[0] = b_lane[i];
          for (int d = 1; d < i; d++) begin
            a_sr_d[d] = a_sr_q[d-1];
            b_sr_d[d] = b_sr_q[d-1];
          end
        end
      end
      // NOTE: these register arrays are reset because a flush must see clean zeros, not stale data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sr_q <= '{default: '0};
          b_sr_q <= '{default: '0};
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end
      assign a_pe[i][0] = a_sr_q[i-1];
      assign b_pe[0][i] = b_sr_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [AW-1:0]          acc_q, acc_d;
      logic signed [2*OW-1:0] prod;
      assign prod = a_pe[i][j] * b_pe[i][j];
      always_comb begin
        acc_d = acc_q;
        if (clr)      acc_d = '0;
        else if (adv) acc_d = acc_q + AW'(prod);
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
      end
      assign acc[i][j] = acc_q;

      if (j < N-1) begin : g_pass_a
        logic signed [OW-1:0] a_q, a_d;
        always_comb begin
          a_d = a_q;
          if (clr)      a_d = '0;
          else if (adv) a_d = a_pe[i][j];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) a_q <= '0;
          else        a_q <= a_d;
        end
        assign a_pe[i][j+1] = a_q;
      end

      if (i < N-1) begin : g_pass_b
        logic signed [OW-1:0] b_q, b_d;
        always_comb begin
          b_d = b_q;
          if (clr)      b_d = '0;
          else if (adv) b_d = b_pe[i][j];
        end
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) b_q <= '0;
          else        b_q <= b_d;
        end
        assign b_pe[i+1][j] = b_q;
      end
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == S_DRAIN) begin
      for (int j = 0; j < N; j++) out_row[j*AW +: AW] = acc[rcnt_q][j];
    end
  end

endmodule

// File: tb/tb_sa_tile_os_param.sv
// Self-checking bench for sa_tile_os_param: directed GEMM tiles plus randomized tiles
// and stalls, compared against a plain-arithmetic matrix-product model.
module tb_sa_tile_os_param;
  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 18;
  localparam int KW   = 16;
  localparam int KMAX = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic [DW:0]     a_offset;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_vec;
  logic [N*DW-1:0] b_vec;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_row;
  logic            out_last;
  logic            busy;
  logic            done;

  sa_tile_os_param #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .a_offset(a_offset),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int a_m [N][KMAX];
  int b_m [KMAX][N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // C[r][c] = sum_k a_eff(A[r][k]) * b_eff(B[k][c]) mod 2^AW
  function automatic logic [AW-1:0] ref_c(input int r, input int c, input int k,
                                          input bit sm, input int off);
    longint s = 0;
    for (int t = 0; t < k; t++) begin
      int av = a_m[r][t];
      int bv = b_m[t][c];
      if (sm) begin
        av = ((av >= 128) ? av - 256 : av) + off;
        av = ((av + 256) & 511) - 256;
        bv = (bv >= 128) ? bv - 256 : bv;
      end
      s += longint'(av) * longint'(bv);
    end
    return s[AW-1:0];
  endfunction

  task automatic run_tile(input string tag, input int k, input bit sm, input int off,
                          input int in_mode, input int out_mode, input bit start_in_drain);
    int kk  = 0;
    int cyc = 0;
    int r   = 0;
    int lat = 0;
    @(negedge clk);
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    start       = 1'b1;
    k_len       = KW'(k);
    signed_mode = sm;
    a_offset    = 9'(off);
    @(negedge clk);
    start       = 1'b0;
    k_len       = KW'($urandom);
    signed_mode = ~sm;
    a_offset    = 9'($urandom);
    #1 check({tag, " busy"}, 64'(busy), 64'd1);
    while (kk < k && cyc < 2000) begin
      case (in_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      for (int i = 0; i < N; i++) begin
        a_vec[i*DW +: DW] = DW'(a_m[i][kk]);
        b_vec[i*DW +: DW] = DW'(b_m[kk][i]);
      end
      #1;
      if (in_valid && in_ready) kk++;
      cyc++;
      @(negedge clk);
    end
    check({tag, " beats"}, 64'(kk), 64'(k));
    if (k > 0) begin
      in_valid = 1'b1;
      a_vec    = N*DW'($urandom);
      b_vec    = N*DW'($urandom);
      #1 check({tag, " in_ready_flush"}, 64'(in_ready), 64'd0);
      lat = 1;
      while (!out_valid && lat < 100) begin
        @(negedge clk);
        #1;
        lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(2*N - 1));
      in_valid = 1'b0;
    end
    cyc = 0;
    while (r < N && cyc < 300) begin
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 2);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (start_in_drain) start = 1'b1;
      #1;
      check($sformatf("%s valid r%0d", tag, r), 64'(out_valid), 64'd1);
      for (int j = 0; j < N; j++)
        check($sformatf("%s C[%0d][%0d]", tag, r, j), 64'(out_row[j*AW +: AW]),
              64'(ref_c(r, j, k, sm, off)));
      check($sformatf("%s last r%0d", tag, r), 64'(out_last), 64'(r == N-1));
      check($sformatf("%s done r%0d", tag, r), 64'(done), 64'(out_ready && r == N-1));
      if (out_valid && out_ready) r++;
      cyc++;
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b0;
    #1;
    check({tag, " rows"}, 64'(r), 64'(N));
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " idle_valid"}, 64'(out_valid), 64'd0);
    check({tag, " idle_done"}, 64'(done), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flags"}, 64'({in_ready, out_valid, out_last, busy, done}), 64'd0);
    check({tag, " row"}, 64'(out_row), 64'd0);
  endtask

  task automatic fill(input int a_val, input int b_val);
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KMAX; t++) begin
        a_m[i][t] = a_val;
        b_m[t][i] = b_val;
      end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; signed_mode = 1'b0; a_offset = '0;
    in_valid = 1'b0; a_vec = '0; b_vec = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_all_zero("post_reset");

    // Identity A, B[k][j] = 4k+j: rows of C reproduce rows of B
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KMAX; t++) begin
        a_m[i][t] = (i == t) ? 1 : 0;
        b_m[t][i] = t*4 + i;
      end
    run_tile("ident", 4, 1'b1, 0, 0, 0, 1'b0);
    run_tile("ident_stall", 4, 1'b0, 0, 1, 1, 1'b0);

    fill(128, 128);
    run_tile("sext", 4, 1'b1, 0, 0, 0, 1'b0);
    run_tile("sext_off", 4, 1'b1, 128, 0, 0, 1'b0);

    fill(255, 255);
    run_tile("unsigned", 3, 1'b0, 5, 0, 0, 1'b0);

    run_tile("k0", 0, 1'b1, 7, 0, 1, 1'b1);

    fill(127, 127);
    run_tile("big", 9, 1'b1, 0, 0, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++)
        for (int t = 0; t < KMAX; t++) begin
          a_m[i][t] = int'($urandom_range(0, 255));
          b_m[t][i] = int'($urandom_range(0, 255));
        end
      run_tile($sformatf("rand%0d", n), int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 511)) - 256, 2, 2, 1'($urandom_range(0, 1)));
    end

    // Abort mid-LOAD, then a clean tile must still produce correct results
    @(negedge clk);
    start = 1'b1; k_len = KW'(8); signed_mode = 1'b1; a_offset = '0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_vec = '1; b_vec = '1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 check_all_zero("abort_release");
    fill(3, 250);
    run_tile("after_abort", 5, 1'b1, -2, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
